mem_bus_arbiter: RTL and testbench

- Shares the single SRAM-style memory bus between two requesters:
  - the instruction-fetch port (IF, read-only);
  - the data port of the MEM stage (load/store, byte mask).
- Sits between the pipeline and the memory/bridge.
- Latches one request at a time, holds the bus stable until completion, and steers the response back to the owner.
- Data port has priority, with a starvation guard for IF. On an exception flush, in-flight fetch responses are discarded.

---
 rtl/mem_bus_arbiter.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one SRAM-style memory bus between the instruction-fetch port (IF,
//   read-only) and the MEM-stage data port (load/store with byte mask). One
//   request is latched at a time. The bus is held stable until it completes,
//   and the response is steered back to the requester that owns the bus.
//   The data port has priority. A starvation counter forces an IF grant after
//   STARVE_LIMIT consecutive data grants made while IF was waiting.
//
// Optional build macro: MEM_ARB_PERF_EN adds the perf_igrant, perf_dgrant and
//   perf_stall counter outputs.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   excp_flush        pipeline exception flush (drops in-flight fetch data)
//   i_en/i_addr       fetch request (held until i_rdata_valid)
//   i_rdata[_valid]   fetch response, one-cycle valid pulse
//   d_en/d_we/d_addr/d_wmask/d_wdata   data request (held until response)
//   d_rdata[_valid], d_write_finish    data response pulses
//   mem_en/we/addr/wmask/wdata         bus request (registered, stable)
//   mem_rdata[_valid], mem_write_finish  bus completion inputs
//   perf_igrant/perf_dgrant/perf_stall  (MEM_ARB_PERF_EN only) event counters

module mem_bus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        excp_flush,

    input  logic        i_en,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_rdata_valid,

    input  logic        d_en,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wmask,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_rdata_valid,
    output logic        d_write_finish,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid,
    input  logic        mem_write_finish
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_igrant,
    output logic [31:0] perf_dgrant,
    output logic [31:0] perf_stall
`endif
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    // Latched bus request; the bus is driven only from this register.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } bus_req_t;

    state_t   state_q, state_d;
    bus_req_t req_q, req_d;
    logic [3:0] starve_q, starve_d;
    logic     drop_q, drop_d;
    logic     grant_i, grant_d;
    logic     done;

    // ------------------------------------------------------------------
    // Next-state / arbitration
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        starve_d = starve_q;
        drop_d   = drop_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                // A flush cycle never starts a transaction: the fetch being
                // requested belongs to the squashed path.
                if (!excp_flush) begin
                    if (d_en && (!i_en || (starve_q < LIMIT))) begin
                        grant_d     = 1'b1;
                        state_d     = DBUSY;
                        req_d.we    = d_we;
                        req_d.addr  = d_addr;
                        req_d.wmask = d_wmask;
                        req_d.wdata = d_wdata;
                        if (i_en)
                            starve_d = (starve_q == 4'hF) ? 4'hF : starve_q + 4'd1;
                        else
                            starve_d = 4'd0;
                    end else if (i_en) begin
                        grant_i     = 1'b1;
                        state_d     = IBUSY;
                        req_d.we    = 1'b0;
                        req_d.addr  = i_addr;
                        req_d.wmask = 4'b0000;
                        req_d.wdata = 32'd0;
                        starve_d    = 4'd0;
                    end
                end
            end
            IBUSY: begin
                // Only a read completion ends a fetch.
                done = mem_rdata_valid;
                // The bus cycle must still finish, so a flush just marks the
                // returning data as unwanted.
                if (excp_flush)
                    drop_d = 1'b1;
                if (done) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
            end
            DBUSY: begin
                // Completion kind follows the latched direction; the other
                // pulse is ignored. Flush does not affect data transactions.
                done = req_q.we ? mem_write_finish : mem_rdata_valid;
                if (done)
                    state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            req_q    <= '0;
            starve_q <= 4'd0;
            drop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            starve_q <= starve_d;
            drop_q   <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus outputs: decoded from registered state only, so they are stable
    // for the whole transaction.
    // ------------------------------------------------------------------
    assign mem_en    = (state_q != IDLE);
    assign mem_we    = req_q.we;
    assign mem_addr  = req_q.addr;
    assign mem_wmask = req_q.wmask;
    assign mem_wdata = req_q.wdata;

    // ------------------------------------------------------------------
    // Response steering, same cycle as the bus completion pulse
    // ------------------------------------------------------------------
    always_comb begin
        i_rdata        = 32'd0;
        i_rdata_valid  = 1'b0;
        d_rdata        = 32'd0;
        d_rdata_valid  = 1'b0;
        d_write_finish = 1'b0;
        case (state_q)
            IBUSY: begin
                i_rdata       = mem_rdata;
                // A flush in the completion cycle itself must also squash.
                i_rdata_valid = done & ~drop_q & ~excp_flush;
            end
            DBUSY: begin
                d_rdata        = mem_rdata;
                d_rdata_valid  = done & ~req_q.we;
                d_write_finish = done &  req_q.we;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap at 2^32)
    // ------------------------------------------------------------------
    logic i_stall, d_stall;

    // A requester is stalled when it asks but neither wins this cycle nor
    // already owns the bus.
    assign i_stall = i_en & ~grant_i & (state_q != IBUSY);
    assign d_stall = d_en & ~grant_d & (state_q != DBUSY);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_igrant <= 32'd0;
            perf_dgrant <= 32'd0;
            perf_stall  <= 32'd0;
        end else begin
            if (grant_i)
                perf_igrant <= perf_igrant + 32'd1;
            if (grant_d)
                perf_dgrant <= perf_dgrant + 32'd1;
            if (i_stall | d_stall)
                perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

    localparam int LIMIT    = 4;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        excp_flush;
    logic        i_en;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rdata_valid;
    logic        d_en;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_wmask;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;
    logic        d_write_finish;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;
    logic        mem_write_finish;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_igrant;
    logic [31:0] perf_dgrant;
    logic [31:0] perf_stall;
`endif

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk              (clk),
        .reset            (reset),
        .excp_flush       (excp_flush),
        .i_en             (i_en),
        .i_addr           (i_addr),
        .i_rdata          (i_rdata),
        .i_rdata_valid    (i_rdata_valid),
        .d_en             (d_en),
        .d_we             (d_we),
        .d_addr           (d_addr),
        .d_wmask          (d_wmask),
        .d_wdata          (d_wdata),
        .d_rdata          (d_rdata),
        .d_rdata_valid    (d_rdata_valid),
        .d_write_finish   (d_write_finish),
        .mem_en           (mem_en),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wmask        (mem_wmask),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_rdata_valid  (mem_rdata_valid),
        .mem_write_finish (mem_write_finish)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_igrant      (perf_igrant),
        .perf_dgrant      (perf_dgrant),
        .perf_stall       (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Inputs change at the falling edge; outputs are sampled #1 later.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        excp_flush       = 1'b0;
        i_en             = 1'b0;
        i_addr           = 32'd0;
        d_en             = 1'b0;
        d_we             = 1'b0;
        d_addr           = 32'd0;
        d_wmask          = 4'd0;
        d_wdata          = 32'd0;
        mem_rdata        = 32'd0;
        mem_rdata_valid  = 1'b0;
        mem_write_finish = 1'b0;
    endtask

    // Leaves the caller at a falling edge with reset just released (cycle 0).
    task automatic do_reset();
        step();
        clear_inputs();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({mem_en, mem_we, mem_wmask} !== 6'd0) begin
            errors++; $display("FAIL reset_bus_ctl got=%b exp=000000", {mem_en, mem_we, mem_wmask});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
            errors++; $display("FAIL reset_bus_data addr=%h wdata=%h exp=0", mem_addr, mem_wdata);
        end
        checks++;
        if ({i_rdata_valid, d_rdata_valid, d_write_finish} !== 3'd0 || i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_resp got iv=%b dv=%b wf=%b ird=%h drd=%h exp=0",
                               i_rdata_valid, d_rdata_valid, d_write_finish, i_rdata, d_rdata);
        end
    endtask

    task automatic test_fetch();
        do_reset();
        i_en = 1'b1; i_addr = 32'h1C00_0000;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL fetch_c0_mem_en got=%b exp=0", mem_en); end
        for (int c = 1; c <= 4; c++) begin
            step();
            mem_rdata_valid = (c == 4);
            mem_rdata       = (c == 4) ? 32'h0280_0C00 : 32'h0;
            #1;
            checks++;
            if (mem_en !== 1'b1 || mem_addr !== 32'h1C00_0000 || mem_we !== 1'b0) begin
                errors++; $display("FAIL fetch_bus c%0d en=%b addr=%h we=%b exp 1/1c000000/0", c, mem_en, mem_addr, mem_we);
            end
            checks++;
            if (i_rdata_valid !== 1'(c == 4)) begin
                errors++; $display("FAIL fetch_valid c%0d got=%b exp=%b", c, i_rdata_valid, (c == 4));
            end
        end
        checks++;
        if (i_rdata !== 32'h0280_0C00) begin errors++; $display("FAIL fetch_data got=%h exp=02800c00", i_rdata); end
        step();
        i_en = 1'b0; mem_rdata_valid = 1'b0;
        #1;
        checks++;
        if (mem_en !== 1'b0 || i_rdata_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_c5 en=%b iv=%b exp=0/0", mem_en, i_rdata_valid);
        end
    endtask

    task automatic test_store_priority();
        do_reset();
        d_en = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wmask = 4'b0011; d_wdata = 32'hDEAD_BEEF;
        i_en = 1'b1; i_addr = 32'h2000;
        #1;
        step(); #1;
        checks++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wmask !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL prio_store_bus en=%b we=%b addr=%h mask=%b wd=%h exp 1/1/100/0011/deadbeef",
                               mem_en, mem_we, mem_addr, mem_wmask, mem_wdata);
        end
        step(); mem_write_finish = 1'b1; #1;
        checks++;
        if (d_write_finish !== 1'b1 || d_rdata_valid !== 1'b0 || i_rdata_valid !== 1'b0) begin
            errors++; $display("FAIL prio_store_finish wf=%b dv=%b iv=%b exp 1/0/0", d_write_finish, d_rdata_valid, i_rdata_valid);
        end
        step(); mem_write_finish = 1'b0; d_en = 1'b0; #1;
        checks++;
        if (mem_en !== 1'b0 || d_write_finish !== 1'b0) begin
            errors++; $display("FAIL prio_gap en=%b wf=%b exp 0/0", mem_en, d_write_finish);
        end
        step(); #1;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h2000 || mem_we !== 1'b0 || mem_wmask !== 4'b0000) begin
            errors++; $display("FAIL prio_fetch_bus en=%b addr=%h we=%b mask=%b exp 1/2000/0/0000", mem_en, mem_addr, mem_we, mem_wmask);
        end
        step(); mem_rdata_valid = 1'b1; mem_rdata = 32'h0000_55AA; #1;
        checks++;
        if (i_rdata_valid !== 1'b1 || i_rdata !== 32'h0000_55AA || d_rdata_valid !== 1'b0) begin
            errors++; $display("FAIL prio_fetch_resp iv=%b ird=%h dv=%b exp 1/000055aa/0", i_rdata_valid, i_rdata, d_rdata_valid);
        end
        step(); clear_inputs();
    endtask

    task automatic test_starvation();
        int n;
        int cyc;
        bit is_if [10];
        do_reset();
        i_en = 1'b1; i_addr = 32'hA000;
        d_en = 1'b1; d_we = 1'b0; d_addr = 32'hB000;
        n = 0; cyc = 0;
        // Bus answers in the first cycle of every transaction.
        while (n < 10 && cyc < 200) begin
            step();
            mem_rdata_valid = 1'b0;
            if (mem_en === 1'b1) begin
                is_if[n] = (mem_addr == 32'hA000);
                mem_rdata_valid = 1'b1;
                n++;
            end
            cyc++;
        end
        step(); clear_inputs();
        checks++;
        if (n != 10) begin errors++; $display("FAIL starve_grant_count got=%0d exp=10", n); end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (is_if[k] !== (k % (LIMIT + 1) == LIMIT)) begin
                errors++; $display("FAIL starve_order grant%0d is_if=%b exp=%b", k, is_if[k], (k % (LIMIT + 1) == LIMIT));
            end
        end
    endtask

    task automatic test_flush_ibusy();
        do_reset();
        i_en = 1'b1; i_addr = 32'h0000_4000;
        #1;
        step(); excp_flush = 1'b1; #1;
        checks++;
        if (mem_en !== 1'b1 || i_rdata_valid !== 1'b0) begin
            errors++; $display("FAIL flush_c1 en=%b iv=%b exp 1/0", mem_en, i_rdata_valid);
        end
        step(); excp_flush = 1'b0; i_en = 1'b0; #1;
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL flush_hold en=%b exp=1", mem_en); end
        step(); mem_rdata_valid = 1'b1; mem_rdata = 32'h1111_2222; #1;
        checks++;
        if (mem_en !== 1'b1 || i_rdata_valid !== 1'b0) begin
            errors++; $display("FAIL flush_suppress en=%b iv=%b exp 1/0", mem_en, i_rdata_valid);
        end
        // A fresh fetch right after must go through normally.
        step(); mem_rdata_valid = 1'b0; i_en = 1'b1; i_addr = 32'h0000_5000; #1;
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL flush_idle en=%b exp=0", mem_en); end
        step(); mem_rdata_valid = 1'b1; mem_rdata = 32'h3333_4444; #1;
        checks++;
        if (mem_addr !== 32'h5000 || i_rdata_valid !== 1'b1 || i_rdata !== 32'h3333_4444) begin
            errors++; $display("FAIL flush_refetch addr=%h iv=%b ird=%h exp 5000/1/33334444", mem_addr, i_rdata_valid, i_rdata);
        end
        step(); clear_inputs();
    endtask

    task automatic test_wrong_pulse();
        do_reset();
        d_en = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        #1;
        // Flush during a data transaction must not disturb it.
        step(); mem_write_finish = 1'b1; excp_flush = 1'b1; #1;
        checks++;
        if (mem_en !== 1'b1 || d_rdata_valid !== 1'b0 || d_write_finish !== 1'b0) begin
            errors++; $display("FAIL wrong_pulse_ignored en=%b dv=%b wf=%b exp 1/0/0", mem_en, d_rdata_valid, d_write_finish);
        end
        step(); mem_write_finish = 1'b0; excp_flush = 1'b0; #1;
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL wrong_pulse_hold en=%b exp=1", mem_en); end
        step(); mem_rdata_valid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        checks++;
        if (d_rdata_valid !== 1'b1 || d_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL wrong_pulse_load dv=%b drd=%h exp 1/12345678", d_rdata_valid, d_rdata);
        end
        step(); mem_rdata_valid = 1'b0; d_en = 1'b0; #1;
        checks++;
        if (mem_en !== 1'b0 || d_rdata_valid !== 1'b0) begin
            errors++; $display("FAIL wrong_pulse_end en=%b dv=%b exp 0/0", mem_en, d_rdata_valid);
        end
    endtask

    task automatic test_random();
        int own, own_n, starve, lat_cnt;
        bit idrop, i_pend, d_pend, done, exp_iv, exp_dv, exp_df;
        logic        l_we;
        logic [31:0] l_addr, l_wdata;
        logic [3:0]  l_wmask;
        do_reset();
        own = OWN_NONE; starve = 0; lat_cnt = 0; idrop = 0; i_pend = 0; d_pend = 0;
        l_we = 0; l_addr = 0; l_wdata = 0; l_wmask = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc > 0) step();
            excp_flush = ($urandom_range(0, 15) == 0);
            if (!i_pend && $urandom_range(0, 2) == 0) begin
                i_pend = 1; i_addr = $urandom;
            end
            if (!d_pend && $urandom_range(0, 2) == 0) begin
                d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
                d_wmask = 4'($urandom_range(0, 15)); d_wdata = $urandom;
            end
            i_en = i_pend; d_en = d_pend;
            mem_rdata = $urandom; mem_rdata_valid = 1'b0; mem_write_finish = 1'b0; done = 0;
            if (own == OWN_NONE) begin
                mem_rdata_valid  = ($urandom_range(0, 7) == 0);
                mem_write_finish = ($urandom_range(0, 7) == 0);
            end else if (lat_cnt == 0) begin
                done = 1;
                if (own == OWN_D && l_we) mem_write_finish = 1'b1;
                else                      mem_rdata_valid  = 1'b1;
            end else begin
                lat_cnt--;
                if ($urandom_range(0, 3) == 0) begin
                    if (own == OWN_D && l_we) mem_rdata_valid  = 1'b1;
                    else                      mem_write_finish = 1'b1;
                end
            end
            exp_iv = (own == OWN_I) && done && !idrop && !excp_flush;
            exp_dv = (own == OWN_D) && done && !l_we;
            exp_df = (own == OWN_D) && done && l_we;
            #1;
            checks++;
            if (mem_en !== 1'(own != OWN_NONE)) begin
                errors++; $display("FAIL rnd_mem_en cyc%0d got=%b exp=%b", cyc, mem_en, (own != OWN_NONE));
            end
            if (own != OWN_NONE) begin
                checks++;
                if (mem_addr !== l_addr || mem_we !== l_we || mem_wmask !== l_wmask || (own == OWN_D && mem_wdata !== l_wdata)) begin
                    errors++; $display("FAIL rnd_bus cyc%0d addr=%h we=%b mask=%b wd=%h exp %h/%b/%b/%h",
                                       cyc, mem_addr, mem_we, mem_wmask, mem_wdata, l_addr, l_we, l_wmask, l_wdata);
                end
            end
            checks++;
            if (i_rdata_valid !== exp_iv || d_rdata_valid !== exp_dv || d_write_finish !== exp_df) begin
                errors++; $display("FAIL rnd_valids cyc%0d iv=%b dv=%b wf=%b exp %b/%b/%b",
                                   cyc, i_rdata_valid, d_rdata_valid, d_write_finish, exp_iv, exp_dv, exp_df);
            end
            checks++;
            if ((own == OWN_I && exp_iv && i_rdata !== mem_rdata) || (own != OWN_I && i_rdata !== 32'd0)) begin
                errors++; $display("FAIL rnd_i_rdata cyc%0d got=%h", cyc, i_rdata);
            end
            checks++;
            if ((own == OWN_D && exp_dv && d_rdata !== mem_rdata) || (own != OWN_D && d_rdata !== 32'd0)) begin
                errors++; $display("FAIL rnd_d_rdata cyc%0d got=%h", cyc, d_rdata);
            end
            // Requester and arbiter model advance to the next cycle.
            if (exp_iv) i_pend = 0;
            if (exp_dv || exp_df) d_pend = 0;
            own_n = own;
            if (own == OWN_NONE) begin
                idrop = 0;
                lat_cnt = $urandom_range(0, 3);
                if (!excp_flush) begin
                    if (d_en && (!i_en || starve < LIMIT)) begin
                        own_n = OWN_D; l_we = d_we; l_addr = d_addr; l_wmask = d_wmask; l_wdata = d_wdata;
                        starve = i_en ? ((starve < 15) ? starve + 1 : 15) : 0;
                    end else if (i_en) begin
                        own_n = OWN_I; l_we = 0; l_addr = i_addr; l_wmask = 0; l_wdata = 0;
                        starve = 0;
                    end
                end
            end else begin
                if (own == OWN_I && excp_flush) idrop = 1;
                if (done) begin own_n = OWN_NONE; idrop = 0; end
            end
            // A flushed fetch is abandoned by the pipeline.
            if (excp_flush) i_pend = 0;
            own = own_n;
        end
        step(); clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        d_en = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        #1;
        step(); #1;
        checks++;
        if (mem_en !== 1'b1) begin errors++; $display("FAIL rstmid_busy en=%b exp=1", mem_en); end
        reset = 1'b1;
        step(); reset = 1'b0; d_en = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'd0 || mem_wmask !== 4'd0) begin
            errors++; $display("FAIL rstmid_bus en=%b we=%b addr=%h mask=%b exp 0", mem_en, mem_we, mem_addr, mem_wmask);
        end
        checks++;
        if (d_rdata_valid !== 1'b0 || d_rdata !== 32'd0 || i_rdata_valid !== 1'b0 || i_rdata !== 32'd0) begin
            errors++; $display("FAIL rstmid_resp dv=%b drd=%h iv=%b ird=%h exp 0", d_rdata_valid, d_rdata, i_rdata_valid, i_rdata);
        end
        step(); mem_rdata_valid = 1'b0; #1;
        checks++;
        if (mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_idle en=%b exp=0", mem_en); end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_fetch();
        test_store_priority();
        test_starvation();
        test_flush_ibusy();
        test_wrong_pulse();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
